xext_bridge: RTL

XEXT_BRIDGE -- requirements
Module: xext_bridge

---
 rtl/xext_bridge.sv | 106 ++++++++++
 1 files changed

// File: rtl/xext_bridge.sv
// Bridges one core access onto a registered external request bus: capture in IDLE, hold ext_req until ack or abort, one DONE cycle.
// Latency: ack at BUSY cycle k gives DONE k+1 cycles after sel; the core is held through `stall` until then, and there is no other backpressure.
module xext_bridge #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_to_wr,
    output logic [DATA_W-1:0] data_to_rd,
    output logic              stall,
    output logic              timeout,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ack,
    input  logic [DATA_W-1:0] ext_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic              r_ext_req;
    logic              r_ext_we;
    logic [ADDR_W-1:0] r_ext_addr;
    logic [DATA_W-1:0] r_ext_wdata;
    logic [DATA_W-1:0] r_data_to_rd;
    logic              r_timeout;
    logic              w_expire;

    assign w_expire = (r_cnt == LP_LAST);

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                stall = sel;
                if (sel) w_state_nxt = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (ext_ack || w_expire) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ext_req    <= 1'b0;
            r_ext_we     <= 1'b0;
            r_ext_addr   <= '0;
            r_ext_wdata  <= '0;
            r_data_to_rd <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sel) begin
                        r_ext_req   <= 1'b1;
                        r_ext_we    <= we;
                        r_ext_addr  <= addr;
                        r_ext_wdata <= data_to_wr;
                        r_cnt       <= '0;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Ack takes priority over an abort landing in the same cycle.
                    if (ext_ack) begin
                        r_ext_req <= 1'b0;
                        if (!r_ext_we) r_data_to_rd <= ext_rdata;
                    end else if (w_expire) begin
                        r_ext_req <= 1'b0;
                        r_timeout <= 1'b1;
                        if (!r_ext_we) r_data_to_rd <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ext_req    = r_ext_req;
    assign ext_we     = r_ext_we;
    assign ext_addr   = r_ext_addr;
    assign ext_wdata  = r_ext_wdata;
    assign data_to_rd = r_data_to_rd;
    assign timeout    = r_timeout;

endmodule
